// File: rtl/regfile_onehot_wr.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_onehot_wr
//  Description : RV32 integer register file with a one-hot write select,
//                two combinational read ports, hardwired-zero x0, optional
//                write-to-read bypass and a sticky malformed-select flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_onehot_wr #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,  // must stay 32: the write select comes from a 5-to-32 decoder
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [31:0]     wr_onehot,
  input  logic [XLEN-1:0] wr_data,
  input  logic [4:0]      rd_addr_a,
  input  logic [4:0]      rd_addr_b,
  output logic [XLEN-1:0] rd_data_a,
  output logic [XLEN-1:0] rd_data_b,
  input  logic            err_clr,
  output logic            onehot_err
);

  logic [XLEN-1:0] regs [0:NREGS-1];
  logic            onehot_ok;
  logic            wr_legal;
  logic            wr_illegal;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  always_comb begin
    onehot_ok  = (wr_onehot != 32'd0) && ((wr_onehot & (wr_onehot - 32'd1)) == 32'd0);
    wr_legal   = wr_en && onehot_ok;
    wr_illegal = wr_en && !onehot_ok;
  end

  // x0 never stores anything; a bit-0 select is legal but lands nowhere.
  generate
    begin : g_x0
      assign regs[0] = '0;
    end
  endgenerate

  generate
    for (genvar i = 1; i < NREGS; i++) begin : g_reg
      // Register xi loads only on a legal write whose select bit i is set.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs[i] <= '0;
        end else if (wr_legal && wr_onehot[i]) begin
          regs[i] <= wr_data;
        end
      end
    end
  endgenerate

  // Sticky error flag; a new illegal strobe beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_err <= 1'b0;
    end else if (wr_illegal) begin
      onehot_err <= 1'b1;
    end else if (err_clr) begin
      onehot_err <= 1'b0;
    end
  end

  // Read port A: array lookup, optional same-cycle forward, forced 0 in reset.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if ((BYPASS != 0) && wr_legal && wr_onehot[rd_addr_a] && (rd_addr_a != 5'd0)) begin
      rd_data_a = wr_data;
    end
    if (!rst_n) begin
      rd_data_a = '0;
    end
  end

  // Read port B: identical structure to port A.
  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if ((BYPASS != 0) && wr_legal && wr_onehot[rd_addr_b] && (rd_addr_b != 5'd0)) begin
      rd_data_b = wr_data;
    end
    if (!rst_n) begin
      rd_data_b = '0;
    end
  end

endmodule
`default_nettype wire
